score_counter: RTL and testbench
================================

SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter MAX_POINTS, default 12; saturation value of the score.
REQ-002 Parameter COOLDOWN_CYCLES, default 4_000_000; hit-ignore window after each scored point, in pclk cycles (100 ms at 40 MHz).
REQ-003 pclk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 hit  input  1  level from collision logic, synchronous to pclk; may stay high for many cycles.
REQ-006 clear  input  1  synchronous game restart; one-cycle or longer pulse.
REQ-007 enable  input  1  scoring allowed (game running); when low, hits are ignored.
REQ-008 points  output  4  registered current score, 0..MAX_POINTS; feeds the 7-segment points display stage.
REQ-009 point_pulse  output  1  registered one-cycle strobe in the cycle points increments.
REQ-010 max_reached  output  1  registered level, high while points == MAX_POINTS.

Function
REQ-011 Rising-edge detect on hit: score event = hit & ~hit_d, where hit_d is hit registered one cycle.
REQ-012 FSM states IDLE, COOLDOWN, DONE; encoding in shared package.
REQ-013 IDLE: score event with enable=1 -> points+1, point_pulse=1 next cycle, cooldown counter loaded with COOLDOWN_CYCLES-1, go COOLDOWN; if new points == MAX_POINTS go DONE instead.
REQ-014 Latency: points and point_pulse update on the first rising pclk edge after the cycle hit is first sampled high.
REQ-015 COOLDOWN: counter decrements each cycle; all score events ignored; counter == 0 -> IDLE.
REQ-016 A hit held high across the end of COOLDOWN does not score; only a new rising edge scores.
REQ-017 DONE: points held at MAX_POINTS, max_reached=1, all hits ignored.
REQ-018 Score never exceeds MAX_POINTS; no wrap-around to 0.
REQ-019 clear (any state) -> next cycle points=0, point_pulse=0, max_reached=0, counter=0, state IDLE; clear has priority over a simultaneous score event.
REQ-020 enable=0 in IDLE: events discarded; enable=0 does not abort an active COOLDOWN.
REQ-021 Cooldown counter width = $clog2(COOLDOWN_CYCLES)+1; COOLDOWN_CYCLES >= 1; COOLDOWN_CYCLES=1 gives exactly one ignored cycle.
REQ-022 point_pulse is high for exactly one cycle per increment and never in the cycle of clear.

Reset
REQ-023 rst asserted -> immediately points=0, point_pulse=0, max_reached=0, hit_d=0, counter=0, state IDLE.
REQ-024 rst asserted mid-COOLDOWN or in DONE -> same values as REQ-023; no pending event survives.
REQ-025 First cycle after rst release with hit already high -> hit_d=0 so the edge counts as a score event (if enable=1).

Structure
REQ-026 Shared package holds FSM state encodings, MAX_POINTS default and COOLDOWN_CYCLES default, shared with points display stage.
REQ-027 One sub-module: edge_detector (pclk, rst, in -> rise pulse), reusable for button inputs.
REQ-028 All outputs driven directly from flops; single sequential block plus combinational next-state logic.

Verification (bench sets COOLDOWN_CYCLES=4)
REQ-029 rst, enable=1, hit held high 10 cycles -> points=1, point_pulse one cycle, no second increment.
REQ-030 Hit pulses every 2 cycles -> only first scores; next pulse after 4-cycle cooldown scores; points=2.
REQ-031 13 spaced hits with MAX_POINTS=12 -> points stops at 12, max_reached=1 after 12th, 13th ignored.
REQ-032 clear in same cycle as hit edge at points=5 -> points=0, point_pulse=0, state IDLE.
REQ-033 rst asserted asynchronously mid-COOLDOWN at points=3 -> outputs 0 before next pclk edge; fresh hit after release -> points=1.
REQ-034 enable=0 with hit edges -> points unchanged at 0; enable=1 then edge -> points=1.

Source files
------------

// File: rtl/score_counter_pkg.sv
// score_counter_pkg: FSM encoding and default parameters shared with the points display stage
package score_counter_pkg;
  typedef enum logic [1:0] {IDLE, COOLDOWN, DONE} state_t;
  localparam int MAX_POINTS_DEFAULT = 12;
  localparam int COOLDOWN_CYCLES_DEFAULT = 4_000_000;
endpackage

// File: rtl/score_counter_edge_detector.sv
// edge_detector: one-cycle rise strobe for a level input synchronous to pclk
module edge_detector (
  input  logic pclk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic in_d;
  always_ff @(posedge pclk or posedge rst)
    if (rst) in_d <= 1'b0;
    else in_d <= in;
  assign rise = in & ~in_d;
endmodule

// File: rtl/score_counter.sv
// score_counter: hit-edge scorer with post-point cooldown and saturation at MAX_POINTS
module score_counter
  import score_counter_pkg::*;
#(
  parameter int MAX_POINTS = MAX_POINTS_DEFAULT,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEFAULT
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] points,
  output logic       point_pulse,
  output logic       max_reached
);
  localparam int CW = $clog2(COOLDOWN_CYCLES) + 1;
  localparam logic [3:0] MAX = 4'(MAX_POINTS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] points_n;
  logic rise, score;
  edge_detector u_edge (.pclk(pclk), .rst(rst), .in(hit), .rise(rise));
  always_comb begin
    score = rise & enable & (state == IDLE) & (points != MAX);
    points_n = score ? points + 4'd1 : points;
    state_n = score ? ((points_n == MAX) ? DONE : COOLDOWN)
            : (state == COOLDOWN && cnt == '0) ? IDLE : state;
    cnt_n = score ? CW'(COOLDOWN_CYCLES - 1)
          : (state == COOLDOWN && cnt != '0) ? cnt - CW'(1) : cnt;
  end
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      points <= '0;
      point_pulse <= 1'b0;
      max_reached <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt <= '0;
      points <= '0;
      point_pulse <= 1'b0;
      max_reached <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      points <= points_n;
      point_pulse <= score;
      max_reached <= (points_n == MAX);
    end
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: vector table plus hand sequences, expected outputs queued per driven cycle
module tb_score_counter;
  logic pclk = 0, rst = 0, hit = 0, clear = 0, enable = 0;
  logic [3:0] points;
  logic point_pulse, max_reached;
  typedef struct packed {logic [3:0] points; logic pulse; logic max;} exp_t;
  typedef struct packed {logic hit; logic clear; logic enable; exp_t exp;} vec_t;
  exp_t sb[$];
  vec_t vecs[$];
  int checks = 0, errors = 0;

  score_counter #(.MAX_POINTS(12), .COOLDOWN_CYCLES(4)) dut (
    .pclk(pclk), .rst(rst), .hit(hit), .clear(clear), .enable(enable),
    .points(points), .point_pulse(point_pulse), .max_reached(max_reached)
  );

  always #5 pclk = ~pclk;

  function automatic vec_t v(input logic h, c, e, input logic [3:0] p, input logic pu, m);
    return vec_t'({h, c, e, p, pu, m});
  endfunction

  task automatic drive(input logic h, c, e, input logic [3:0] p, input logic pu, m);
    hit = h;
    clear = c;
    enable = e;
    sb.push_back(exp_t'({p, pu, m}));
  endtask

  task automatic check(input string name);
    exp_t e;
    @(posedge pclk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({points, point_pulse, max_reached} !== e) begin
      errors++;
      $display("FAIL %s: got points=%0d pulse=%0b max=%0b, expected points=%0d pulse=%0b max=%0b",
               name, points, point_pulse, max_reached, e.points, e.pulse, e.max);
    end
  endtask

  task automatic step(input logic h, c, e, input logic [3:0] p, input logic pu, m, input string name);
    @(negedge pclk);
    drive(h, c, e, p, pu, m);
    check(name);
  endtask

  task automatic spaced(input logic [3:0] p, input logic pu, m, input string name);
    step(1, 0, 1, p, pu, m, name);
    repeat (5) step(0, 0, 1, p, 0, m, name);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({points, point_pulse, max_reached} !== 6'b0) begin
      errors++;
      $display("FAIL %s: got points=%0d pulse=%0b max=%0b, expected all zero",
               name, points, point_pulse, max_reached);
    end
  endtask

  initial begin
    // held hit scores once
    vecs.push_back(v(1, 0, 1, 1, 1, 0));
    repeat (9) vecs.push_back(v(1, 0, 1, 1, 0, 0));
    repeat (2) vecs.push_back(v(0, 0, 1, 1, 0, 0));
    // pulses every 2 cycles: only the first and the one after cooldown score
    vecs.push_back(v(0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 2, 1, 0));
    vecs.push_back(v(0, 0, 1, 2, 0, 0));
    // enable low discards edges
    vecs.push_back(v(0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0));

    #2 rst = 1;
    #1 check_zero("reset");
    @(negedge pclk) rst = 0;
    foreach (vecs[i])
      step(vecs[i].hit, vecs[i].clear, vecs[i].enable, vecs[i].exp.points,
           vecs[i].exp.pulse, vecs[i].exp.max, $sformatf("vec%0d", i));

    step(0, 1, 1, 0, 0, 0, "clear_sat");
    for (int i = 1; i <= 12; i++) spaced(4'(i), 1, i == 12, $sformatf("sat%0d", i));
    spaced(12, 0, 1, "sat13");

    step(0, 1, 1, 0, 0, 0, "clear_five");
    for (int i = 1; i <= 5; i++) spaced(4'(i), 1, 0, $sformatf("five%0d", i));
    step(1, 1, 1, 0, 0, 0, "clear_vs_hit");
    step(1, 0, 1, 0, 0, 0, "held_after_clear");
    step(0, 0, 1, 0, 0, 0, "low_after_clear");
    step(1, 0, 1, 1, 1, 0, "idle_after_clear");

    step(0, 1, 1, 0, 0, 0, "clear_rst");
    spaced(1, 1, 0, "rst_pre1");
    spaced(2, 1, 0, "rst_pre2");
    step(1, 0, 1, 3, 1, 0, "rst_pre3");
    step(0, 0, 1, 3, 0, 0, "mid_cooldown");
    #3 rst = 1;
    #1 check_zero("async_rst");
    @(negedge pclk);
    hit = 1;
    enable = 1;
    @(negedge pclk);
    rst = 0;
    drive(1, 0, 1, 1, 1, 0);
    check("hit_after_rst");
    step(1, 0, 1, 1, 0, 0, "held_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
